// File: rtl/param_assoc_cache.sv
// param_assoc_cache: parametrised N-way set-associative write-back,
// write-allocate cache between a core memory port and a backing memory.
// Uses true-LRU ages, supports an explicit flush of dirty lines and has
// one memory transaction outstanding at a time.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   core_req/rsp     core access port (rsp.ready = request accepted this cycle)
//   mem_req/rsp      word-wide backing memory port
//   flush_req        pulse: write back every dirty line (held pending until accepted)
//   flush_busy       high while a flush is in progress
//   flush_done       one-cycle pulse at flush completion
//   stat_hits/misses lookup hit/miss counters
//
// Optional feature macro: PARAM_ASSOC_CACHE_STATS_EN enables saturating
// hit/miss counters; without it both outputs are tied to zero.

package memory_io_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  do_read;
    logic [3:0]  do_write;
    logic        valid;
    logic [2:0]  dummy;
    logic [7:0]  user_tag;
  } memory_io_req;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic [1:0]  dummy;
    logic [7:0]  user_tag;
  } memory_io_rsp;

  localparam memory_io_req memory_io_no_req = '0;
endpackage

module param_assoc_cache
  import memory_io_pkg::*;
#(
  parameter int unsigned NUM_SETS    = 16,
  parameter int unsigned NUM_WAYS    = 4,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  memory_io_req core_req,
  output memory_io_rsp core_rsp,
  output memory_io_req mem_req,
  input  memory_io_rsp mem_rsp,
  input  logic         flush_req,
  output logic         flush_busy,
  output logic         flush_done,
  output logic [31:0]  stat_hits,
  output logic [31:0]  stat_misses
);
  localparam int unsigned SET_BITS  = $clog2(NUM_SETS);
  localparam int unsigned AGE_BITS  = $clog2(NUM_WAYS);
  localparam int unsigned WORD_BITS = $clog2(BLOCK_WORDS);
  localparam int unsigned OFF_BITS  = WORD_BITS + 2;
  localparam int unsigned TAG_BITS  = 32 - SET_BITS - OFF_BITS;
  localparam int unsigned IDX_BITS  = SET_BITS + AGE_BITS;

  typedef logic [31:0] word_t;
  typedef word_t [BLOCK_WORDS-1:0] line_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_WB_WAIT,
    S_FILL_REQ, S_FILL_WAIT, S_FILL_DONE, S_FLUSH_SCAN
  } state_t;

  // Cache storage
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] valid_d [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_d [NUM_SETS];
  logic [TAG_BITS-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0] tag_d   [NUM_SETS][NUM_WAYS];
  line_t               data_q  [NUM_SETS][NUM_WAYS];
  line_t               data_d  [NUM_SETS][NUM_WAYS];
  logic [AGE_BITS-1:0] age_q   [NUM_SETS][NUM_WAYS];
  logic [AGE_BITS-1:0] age_d   [NUM_SETS][NUM_WAYS];

  // Control state
  state_t               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic [7:0]           utag_q, utag_d;
  logic [SET_BITS-1:0]  set_q, set_d;
  logic [AGE_BITS-1:0]  way_q, way_d;
  logic [WORD_BITS-1:0] cnt_q, cnt_d;
  line_t                fill_buf_q, fill_buf_d;
  logic                 flushing_q, flushing_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [IDX_BITS-1:0]  flush_idx_q, flush_idx_d;
  logic                 flush_done_q, flush_done_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic [31:0]          rsp_addr_q, rsp_addr_d;
  logic [7:0]           rsp_tag_q, rsp_tag_d;

  // Decoded captured request
  logic [SET_BITS-1:0]  req_set;
  logic [TAG_BITS-1:0]  req_tag;
  logic [WORD_BITS-1:0] req_word;
  assign req_set  = addr_q[OFF_BITS +: SET_BITS];
  assign req_tag  = addr_q[31 -: TAG_BITS];
  assign req_word = addr_q[2 +: WORD_BITS];

  logic [SET_BITS-1:0] flush_set;
  logic [AGE_BITS-1:0] flush_way;
  assign flush_set = flush_idx_q[IDX_BITS-1 -: SET_BITS];
  assign flush_way = flush_idx_q[AGE_BITS-1:0];

  logic                unused_ok;
  assign unused_ok = ^{core_req.do_read, core_req.dummy, mem_rsp.addr,
                       mem_rsp.ready, mem_rsp.dummy, mem_rsp.user_tag};

  function automatic word_t merge_word(word_t old_w, word_t new_w, logic [3:0] be);
    word_t r;
    r = old_w;
    for (int unsigned b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Tag match and victim selection for the captured request's set
  logic                hit;
  logic [AGE_BITS-1:0] hit_way, victim, inv_way, lru_way;
  logic                inv_found;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int unsigned w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = AGE_BITS'(w);
      end
      if (!valid_q[req_set][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = AGE_BITS'(w);
      end
      if (age_q[req_set][w] == AGE_BITS'(NUM_WAYS - 1)) lru_way = AGE_BITS'(w);
    end
    victim = inv_found ? inv_way : lru_way;
  end

  always_comb begin : main_comb
    logic                touch_en;
    logic [AGE_BITS-1:0] touch_way;
    line_t               line_v;
    word_t               merged;

    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    utag_d       = utag_q;
    set_d        = set_q;
    way_d        = way_q;
    cnt_d        = cnt_q;
    fill_buf_d   = fill_buf_q;
    flushing_d   = flushing_q;
    flush_pend_d = flush_pend_q | flush_req;
    flush_idx_d  = flush_idx_q;
    flush_done_d = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_tag_d    = rsp_tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    age_d        = age_q;
    mem_req      = memory_io_no_req;
    touch_en     = 1'b0;
    touch_way    = way_q;
    line_v       = fill_buf_q;
    merged       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (core_req.valid) begin
          addr_d  = core_req.addr;
          wdata_d = core_req.data;
          be_d    = core_req.do_write;
          utag_d  = core_req.user_tag;
          state_d = S_LOOKUP;
        end else if (flush_pend_d) begin
          flush_pend_d = 1'b0;
          flushing_d   = 1'b1;
          flush_idx_d  = '0;
          state_d      = S_FLUSH_SCAN;
        end
      end

      S_LOOKUP: begin
        set_d = req_set;
        if (hit) begin
          merged = merge_word(data_q[req_set][hit_way][req_word], wdata_q, be_q);
          if (be_q != '0) begin
            data_d[req_set][hit_way][req_word] = merged;
            dirty_d[req_set][hit_way]          = 1'b1;
          end
          way_d       = hit_way;
          touch_en    = 1'b1;
          touch_way   = hit_way;
          rsp_valid_d = 1'b1;
          rsp_data_d  = merged;
          rsp_addr_d  = addr_q;
          rsp_tag_d   = utag_q;
          state_d     = S_IDLE;
        end else begin
          way_d   = victim;
          cnt_d   = '0;
          state_d = (valid_q[req_set][victim] && dirty_q[req_set][victim]) ? S_WB_REQ : S_FILL_REQ;
        end
      end

      S_WB_REQ: begin
        mem_req.valid    = 1'b1;
        mem_req.addr     = {tag_q[set_q][way_q], set_q, cnt_q, 2'b00};
        mem_req.data     = data_q[set_q][way_q][cnt_q];
        mem_req.do_write = 4'b1111;
        mem_req.user_tag = flushing_q ? '0 : utag_q;
        state_d          = S_WB_WAIT;
      end

      S_WB_WAIT: begin
        if (mem_rsp.valid) begin
          if (cnt_q == WORD_BITS'(BLOCK_WORDS - 1)) begin
            cnt_d = '0;
            if (flushing_q) begin
              // Flush returns to the same scan entry; it is now clean, so
              // the scan advances on the next cycle.
              dirty_d[set_q][way_q] = 1'b0;
              state_d               = S_FLUSH_SCAN;
            end else begin
              state_d = S_FILL_REQ;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_WB_REQ;
          end
        end
      end

      S_FILL_REQ: begin
        mem_req.valid    = 1'b1;
        mem_req.addr     = {req_tag, req_set, cnt_q, 2'b00};
        mem_req.do_read  = 4'b1111;
        mem_req.user_tag = utag_q;
        state_d          = S_FILL_WAIT;
      end

      S_FILL_WAIT: begin
        if (mem_rsp.valid) begin
          fill_buf_d[cnt_q] = mem_rsp.data;
          if (cnt_q == WORD_BITS'(BLOCK_WORDS - 1)) begin
            cnt_d   = '0;
            state_d = S_FILL_DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_FILL_REQ;
          end
        end
      end

      S_FILL_DONE: begin
        merged                    = merge_word(fill_buf_q[req_word], wdata_q, be_q);
        line_v[req_word]          = merged;
        data_d[req_set][way_q]    = line_v;
        tag_d[req_set][way_q]     = req_tag;
        valid_d[req_set][way_q]   = 1'b1;
        dirty_d[req_set][way_q]   = (be_q != '0);
        touch_en                  = 1'b1;
        touch_way                 = way_q;
        rsp_valid_d               = 1'b1;
        rsp_data_d                = merged;
        rsp_addr_d                = addr_q;
        rsp_tag_d                 = utag_q;
        state_d                   = S_IDLE;
      end

      S_FLUSH_SCAN: begin
        if (valid_q[flush_set][flush_way] && dirty_q[flush_set][flush_way]) begin
          set_d   = flush_set;
          way_d   = flush_way;
          cnt_d   = '0;
          state_d = S_WB_REQ;
        end else if (flush_idx_q == '1) begin
          flushing_d   = 1'b0;
          flush_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          flush_idx_d = flush_idx_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // LRU touch: touched way becomes youngest, younger ways age by one.
    if (touch_en) begin
      for (int unsigned w = 0; w < NUM_WAYS; w++) begin
        if (AGE_BITS'(w) == touch_way)
          age_d[req_set][w] = '0;
        else if (age_q[req_set][w] < age_q[req_set][touch_way])
          age_d[req_set][w] = age_q[req_set][w] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q      <= '{default: '0};
      dirty_q      <= '{default: '0};
      tag_q        <= '{default: '0};
      data_q       <= '{default: '0};
      for (int unsigned s = 0; s < NUM_SETS; s++)
        for (int unsigned w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= AGE_BITS'(w);
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      utag_q       <= '0;
      set_q        <= '0;
      way_q        <= '0;
      cnt_q        <= '0;
      fill_buf_q   <= '0;
      flushing_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      flush_idx_q  <= '0;
      flush_done_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_addr_q   <= '0;
      rsp_tag_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      age_q        <= age_d;
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      utag_q       <= utag_d;
      set_q        <= set_d;
      way_q        <= way_d;
      cnt_q        <= cnt_d;
      fill_buf_q   <= fill_buf_d;
      flushing_q   <= flushing_d;
      flush_pend_q <= flush_pend_d;
      flush_idx_q  <= flush_idx_d;
      flush_done_q <= flush_done_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_tag_q    <= rsp_tag_d;
    end
  end

  always_comb begin
    core_rsp          = '0;
    core_rsp.valid    = rsp_valid_q;
    core_rsp.data     = rsp_data_q;
    core_rsp.addr     = rsp_addr_q;
    core_rsp.user_tag = rsp_tag_q;
    core_rsp.ready    = (state_q == S_IDLE);
  end

  assign flush_busy = flushing_q;
  assign flush_done = flush_done_q;

`ifdef PARAM_ASSOC_CACHE_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d;

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (state_q == S_LOOKUP) begin
      if (hit && hits_q != '1)      hits_d   = hits_q + 32'd1;
      if (!hit && misses_q != '1)   misses_d = misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_param_assoc_cache.sv
// Directed scoreboard bench for param_assoc_cache (16 sets, 4 ways, 8 words).
// Backing memory answers one cycle after each request; unwritten words read
// as {addr[15:0], 16'h5555}.
module tb_param_assoc_cache;
  import memory_io_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  memory_io_req core_req, mem_req;
  memory_io_rsp core_rsp, mem_rsp;
  logic         flush_req, flush_busy, flush_done;
  logic [31:0]  stat_hits, stat_misses;

  always #5 clk = ~clk;

  param_assoc_cache #(.NUM_SETS(16), .NUM_WAYS(4), .BLOCK_WORDS(8)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_rsp(core_rsp),
    .mem_req(mem_req), .mem_rsp(mem_rsp), .flush_req(flush_req),
    .flush_busy(flush_busy), .flush_done(flush_done),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  // Backing memory model
  logic [31:0] mem [int unsigned];
  typedef struct packed { logic wr; logic [31:0] addr; } txn_t;
  txn_t log_q[$];
  int   rd_count = 0;
  int   wr_count = 0;
  bit   ready_during_mem = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], 16'h5555};
  endfunction

  initial begin
    logic [31:0] rd;
    mem_rsp = '0;
    forever begin
      @(negedge clk);
      if (!reset && mem_req.valid) begin
        if (core_rsp.ready) ready_during_mem = 1;
        if (mem_req.do_write != 4'b0000) begin
          mem[mem_req.addr] = mem_req.data;
          wr_count++;
          log_q.push_back('{1'b1, mem_req.addr});
          rd = '0;
        end else begin
          rd_count++;
          log_q.push_back('{1'b0, mem_req.addr});
          rd = mem_rd(mem_req.addr);
        end
        @(posedge clk); #1;
        mem_rsp.valid = 1'b1;
        mem_rsp.data  = rd;
        @(posedge clk); #1;
        mem_rsp = '0;
      end
    end
  end

  // Scoreboard
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [7:0] tag; int lat; time acc; } exp_t;
  exp_t sb_q[$];

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && core_rsp.valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_rsp: actual=valid addr=%h required=no response", core_rsp.addr);
        end else begin
          e = sb_q.pop_front();
          check("rsp_data", core_rsp.data, e.data);
          check("rsp_addr", core_rsp.addr, e.addr);
          check("rsp_tag", 32'(core_rsp.user_tag), 32'(e.tag));
          if (e.lat > 0) check("rsp_latency", 32'(($time - e.acc) / 10), 32'(e.lat));
        end
      end
    end
  end

  int done_pulses = 0;
  initial forever begin
    @(negedge clk);
    if (flush_done) done_pulses++;
  end

  task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                       input logic [7:0] tag, input logic [31:0] exp_data, input int lat, input bit push);
    int  n = 0;
    time acc;
    @(negedge clk);
    while (!core_rsp.ready && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("ready_timeout", 32'(core_rsp.ready), 32'd1);
    core_req          = '0;
    core_req.valid    = 1'b1;
    core_req.addr     = addr;
    core_req.data     = data;
    core_req.do_write = be;
    core_req.user_tag = tag;
    acc = $time;
    if (push) sb_q.push_back('{addr, exp_data, tag, lat, acc});
    @(posedge clk); #1;
    core_req = '0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (sb_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      check("rsp_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic access(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                        input logic [7:0] tag, input logic [31:0] exp_data, input int lat);
    issue(addr, data, be, tag, exp_data, lat, 1'b1);
    wait_rsp();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    core_req  = '0;
    flush_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
  endtask

  task automatic do_flush(output int writes);
    int w0, p0, n;
    w0 = wr_count;
    p0 = done_pulses;
    n  = 0;
    @(negedge clk);
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    check("flush_busy_start", 32'(flush_busy), 32'd1);
    while (!flush_done && n < 5000) begin @(negedge clk); n++; end
    check("flush_done_seen", 32'(flush_done), 32'd1);
    repeat (3) @(negedge clk);
    check("flush_done_pulses", 32'(done_pulses - p0), 32'd1);
    check("flush_busy_end", 32'(flush_busy), 32'd0);
    writes = wr_count - w0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int r0, w0, fw;
    logic [31:0] exp_h, exp_m;
    reset     = 1'b1;
    core_req  = '0;
    flush_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(core_rsp.ready), 32'd1);
    check("reset_rsp_valid", 32'(core_rsp.valid), 32'd0);
    check("reset_rsp_data", core_rsp.data, 32'd0);
    check("reset_mem_valid", 32'(mem_req.valid), 32'd0);
    check("reset_flush_busy", 32'(flush_busy), 32'd0);
    check("reset_flush_done", 32'(flush_done), 32'd0);
    check("reset_hits", stat_hits, 32'd0);
    check("reset_misses", stat_misses, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Cold load miss: 8 ordered reads, core not ready during fill
    r0 = rd_count; w0 = wr_count; log_q.delete(); ready_during_mem = 0;
    access(32'h0000_1000, 32'h0, 4'b0000, 8'h11, 32'h1000_5555, 0);
    check("miss_reads", 32'(rd_count - r0), 32'd8);
    check("miss_writes", 32'(wr_count - w0), 32'd0);
    for (int i = 0; i < 8; i++)
      if (i < log_q.size()) check("fill_addr", log_q[i].addr, 32'h1000 + 32'(4 * i));
    check("ready_during_fill", 32'(ready_during_mem), 32'd0);

    // Store hit with byte enables, then load hit; no memory traffic
    r0 = rd_count; w0 = wr_count;
    access(32'h0000_1004, 32'hDEAD_BEEF, 4'b0011, 8'h22, 32'h1004_BEEF, 2);
    access(32'h0000_1004, 32'h0, 4'b0000, 8'h23, 32'h1004_BEEF, 2);
    check("hit_mem_traffic", 32'(rd_count - r0 + wr_count - w0), 32'd0);
    exp_h = `ifdef PARAM_ASSOC_CACHE_STATS_EN 32'd2 `else 32'd0 `endif;
    exp_m = `ifdef PARAM_ASSOC_CACHE_STATS_EN 32'd1 `else 32'd0 `endif;
    check("stat_hits", stat_hits, exp_h);
    check("stat_misses", stat_misses, exp_m);

    // Dirty LRU victim written back before the new fill
    do_reset();
    access(32'h0000_0000, 32'h1122_3344, 4'b1111, 8'h30, 32'h1122_3344, 0);
    access(32'h0000_0200, 32'h0, 4'b0000, 8'h31, 32'h0200_5555, 0);
    access(32'h0000_0400, 32'h0, 4'b0000, 8'h32, 32'h0400_5555, 0);
    access(32'h0000_0600, 32'h0, 4'b0000, 8'h33, 32'h0600_5555, 0);
    log_q.delete();
    access(32'h0000_0800, 32'h0, 4'b0000, 8'h34, 32'h0800_5555, 0);
    check("evict_txn_count", 32'(log_q.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < log_q.size()) begin
        check("evict_txn_wr", 32'(log_q[i].wr), (i < 8) ? 32'd1 : 32'd0);
        check("evict_txn_addr", log_q[i].addr, (i < 8) ? 32'(4 * i) : 32'h800 + 32'(4 * (i - 8)));
      end
    check("evict_mem0", mem_rd(32'h0000_0000), 32'h1122_3344);

    // Touching the oldest line redirects eviction to a clean line
    do_reset();
    access(32'h0000_0000, 32'h0, 4'b0000, 8'h40, 32'h1122_3344, 0);
    access(32'h0000_0200, 32'h0, 4'b0000, 8'h41, 32'h0200_5555, 0);
    access(32'h0000_0400, 32'h0, 4'b0000, 8'h42, 32'h0400_5555, 0);
    access(32'h0000_0600, 32'h0, 4'b0000, 8'h43, 32'h0600_5555, 0);
    access(32'h0000_0000, 32'h0, 4'b0000, 8'h44, 32'h1122_3344, 2);
    r0 = rd_count; w0 = wr_count;
    access(32'h0000_0800, 32'h0, 4'b0000, 8'h45, 32'h0800_5555, 0);
    check("lru_clean_writes", 32'(wr_count - w0), 32'd0);
    check("lru_clean_reads", 32'(rd_count - r0), 32'd8);
    access(32'h0000_0000, 32'h0, 4'b0000, 8'h46, 32'h1122_3344, 2);
    check("lru_survivor_reads", 32'(rd_count - r0), 32'd8);

    // Flush two dirty lines, then a second flush with nothing dirty
    do_reset();
    access(32'h0000_0000, 32'hAAAA_0001, 4'b1111, 8'h50, 32'hAAAA_0001, 0);
    access(32'h0000_0020, 32'hBBBB_0002, 4'b1111, 8'h51, 32'hBBBB_0002, 0);
    do_flush(fw);
    check("flush1_writes", 32'(fw), 32'd16);
    check("flush_mem0", mem_rd(32'h0000_0000), 32'hAAAA_0001);
    check("flush_mem20", mem_rd(32'h0000_0020), 32'hBBBB_0002);
    check("flush_mem24", mem_rd(32'h0000_0024), 32'h0024_5555);
    r0 = rd_count;
    access(32'h0000_0000, 32'h0, 4'b0000, 8'h52, 32'hAAAA_0001, 2);
    access(32'h0000_0020, 32'h0, 4'b0000, 8'h53, 32'hBBBB_0002, 2);
    check("flush_reload_reads", 32'(rd_count - r0), 32'd0);
    do_flush(fw);
    check("flush2_writes", 32'(fw), 32'd0);

    // Reset in the middle of a fill aborts it and invalidates lines
    do_reset();
    access(32'h0000_1000, 32'h0, 4'b0000, 8'h60, 32'h1000_5555, 0);
    issue(32'h0000_3000, 32'h0, 4'b0000, 8'h61, 32'h0, 0, 1'b0);
    begin
      int n = 0;
      while (!mem_req.valid && n < 100) begin @(negedge clk); n++; end
    end
    check("abort_req_seen", 32'(mem_req.valid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_mem_valid", 32'(mem_req.valid), 32'd0);
    check("abort_ready", 32'(core_rsp.ready), 32'd1);
    check("abort_hits", stat_hits, 32'd0);
    check("abort_misses", stat_misses, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    r0 = rd_count;
    access(32'h0000_1000, 32'h0, 4'b0000, 8'h62, 32'h1000_5555, 0);
    check("abort_refill_reads", 32'(rd_count - r0), 32'd8);

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
